// File: rtl/autotype_sequencer_pkg.sv
// Shared definitions for the boot-time keystroke injector: step codes, sequencer
// states and extraction of one 4-bit step code from the packed sequence table.
package autotype_sequencer_pkg;

   localparam logic [3:0] CODE_IDLE  = 4'h0;
   localparam logic [3:0] CODE_RESET = 4'hF;

   // Widest possible table: 64 steps of 4 bits each.
   localparam int SEQ_MAX_BITS = 256;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_t;

   function automatic logic [3:0] code_at(input logic [SEQ_MAX_BITS-1:0] seq,
                                          input logic [5:0] i);
      return seq[{i, 2'b00} +: 4];
   endfunction

endpackage

// File: rtl/autotype_sequencer_tick.sv
// Step prescaler: counts clock cycles within a step, flags the last cycle of the
// step and whether the current cycle still lies inside the key-press window.
module autotype_sequencer_tick #(
   parameter int step_cycles  = 2**23,
   parameter int press_cycles = 2**23
) (
   input  logic clk,
   input  logic reset,
   input  logic run,
   input  logic restart,
   output logic step_end,
   output logic press_window
);

   localparam int              CW    = $clog2(step_cycles);
   localparam logic [CW-1:0]   LAST  = CW'(step_cycles - 1);
   localparam logic [31:0]     PRESS = 32'(press_cycles);

   logic [CW-1:0] cnt_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_reg <= '0;
      end else if (restart) begin
         cnt_reg <= '0;
      end else if (run) begin
         cnt_reg <= (cnt_reg == LAST) ? '0 : cnt_reg + CW'(1);
      end
   end

   assign step_end     = run && (cnt_reg == LAST);
   assign press_window = 32'(cnt_reg) < PRESS;

endmodule

// File: rtl/autotype_sequencer.sv
// Boot-time keystroke injector: holds the computer core in reset, then plays a
// parameter-defined table of key presses onto its key inputs.
module autotype_sequencer
   import autotype_sequencer_pkg::*;
#(
   parameter int                    n_keys            = 8,
   parameter int                    seq_len           = 16,
   parameter logic [4*seq_len-1:0]  seq               = 64'h0001_0001_0103_020F,
   parameter int                    step_cycles       = 2**23,
   parameter int                    press_cycles      = 2**23,
   parameter int                    autostart         = 1,
   parameter int                    loop              = 0,
   parameter int                    abort_on_activity = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              user_activity,
   output logic [n_keys-1:0] key,
   output logic              reset_n_out,
   output logic              busy,
   output logic              done,
   output logic              aborted,
   output logic [5:0]        step
);

   localparam logic [SEQ_MAX_BITS-1:0] SEQ_EXT   = SEQ_MAX_BITS'(seq);
   localparam logic [5:0]              LAST_STEP = 6'(seq_len - 1);
   localparam state_t                  RST_STATE = (autostart != 0) ? ST_RUN : ST_IDLE;

   state_t            state_reg;
   logic [5:0]        step_reg;
   logic [n_keys-1:0] key_reg;
   logic [n_keys-1:0] key_next;
   logic              reset_n_reg;
   logic              reset_n_next;
   logic              busy_reg;
   logic              done_reg;
   logic              aborted_reg;
   logic              running;
   logic              abort_now;
   logic              step_end;
   logic              press_window;
   logic [3:0]        cur_code;

   assign running   = (state_reg == ST_RUN);
   assign abort_now = running && (abort_on_activity != 0) && user_activity;
   assign cur_code  = code_at(SEQ_EXT, step_reg);

   autotype_sequencer_tick #(
      .step_cycles  (step_cycles),
      .press_cycles (press_cycles)
   ) u_tick (
      .clk          (clk),
      .reset        (reset),
      .run          (running),
      .restart      (start && !running),
      .step_end     (step_end),
      .press_window (press_window)
   );

   for (genvar gi = 0; gi < n_keys; gi++) begin : g_key
      assign key_next[gi] = running && (cur_code == 4'(gi + 1)) && press_window;
   end

   // IDLE is only reachable from reset, so the core stays held there until start.
   assign reset_n_next = (state_reg != ST_IDLE) && !(running && cur_code == CODE_RESET);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg   <= RST_STATE;
         step_reg    <= '0;
         key_reg     <= '0;
         reset_n_reg <= 1'b0;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
         aborted_reg <= 1'b0;
      end else begin
         key_reg     <= key_next;
         reset_n_reg <= reset_n_next;
         busy_reg    <= running;
         case (state_reg)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state_reg   <= ST_RUN;
                  step_reg    <= '0;
                  done_reg    <= 1'b0;
                  aborted_reg <= 1'b0;
               end
            end
            ST_RUN: begin
               if (abort_now) begin
                  state_reg   <= ST_DONE;
                  done_reg    <= 1'b1;
                  aborted_reg <= 1'b1;
                  key_reg     <= '0;
                  reset_n_reg <= 1'b1;
                  busy_reg    <= 1'b0;
               end else if (step_end) begin
                  if (step_reg != LAST_STEP) begin
                     step_reg <= step_reg + 6'd1;
                  end else if (loop != 0) begin
                     step_reg <= '0;
                  end else begin
                     state_reg <= ST_DONE;
                     done_reg  <= 1'b1;
                  end
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign key         = key_reg;
   assign reset_n_out = reset_n_reg;
   assign busy        = busy_reg;
   assign done        = done_reg;
   assign aborted     = aborted_reg;
   assign step        = step_reg;

endmodule

// File: tb/tb_autotype_sequencer.sv
// Bench for autotype_sequencer: four configurations side by side, checked every
// cycle against a time-based model plus hand-computed literal expectations.
module tb_autotype_sequencer;

   localparam int NI = 4;
   localparam int SC = 8;
   localparam int          P_PC   [NI] = '{5, 5, 5, 8};
   localparam int          P_L    [NI] = '{16, 16, 16, 8};
   localparam int          P_LOOP [NI] = '{0, 0, 1, 0};
   localparam int          P_AUTO [NI] = '{1, 0, 1, 1};
   localparam int          P_AB   [NI] = '{1, 1, 1, 0};
   localparam logic [63:0] P_SEQ  [NI] = '{64'h0001_0001_0103_020F, 64'h0001_0001_0103_020F,
                                           64'h0001_0001_0103_020F, 64'h0000_0000_3E02_C11F};

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start [NI];
   logic       ua    [NI];
   logic [7:0] key_w [NI];
   logic       rn_w  [NI];
   logic       busy_w[NI];
   logic       done_w[NI];
   logic       ab_w  [NI];
   logic [5:0] step_w[NI];

   // Model: phase 0 = never started, 1 = running, 2 = finished; t = cycles since run start.
   int         m_ph [NI];
   int         m_t  [NI];
   logic [7:0] e_key [NI];
   logic       e_rn  [NI];
   logic       e_busy[NI];
   logic       e_done[NI];
   logic       e_ab  [NI];
   int         e_step[NI];

   int tests = 0;
   int fails = 0;
   int e = 0;

   always #5 clk = ~clk;

   autotype_sequencer #(.n_keys(8), .seq_len(16), .seq(64'h0001_0001_0103_020F),
      .step_cycles(SC), .press_cycles(5), .autostart(1), .loop(0), .abort_on_activity(1))
   u0 (.clk(clk), .reset(reset), .start(start[0]), .user_activity(ua[0]), .key(key_w[0]),
      .reset_n_out(rn_w[0]), .busy(busy_w[0]), .done(done_w[0]), .aborted(ab_w[0]), .step(step_w[0]));

   autotype_sequencer #(.n_keys(8), .seq_len(16), .seq(64'h0001_0001_0103_020F),
      .step_cycles(SC), .press_cycles(5), .autostart(0), .loop(0), .abort_on_activity(1))
   u1 (.clk(clk), .reset(reset), .start(start[1]), .user_activity(ua[1]), .key(key_w[1]),
      .reset_n_out(rn_w[1]), .busy(busy_w[1]), .done(done_w[1]), .aborted(ab_w[1]), .step(step_w[1]));

   autotype_sequencer #(.n_keys(8), .seq_len(16), .seq(64'h0001_0001_0103_020F),
      .step_cycles(SC), .press_cycles(5), .autostart(1), .loop(1), .abort_on_activity(1))
   u2 (.clk(clk), .reset(reset), .start(start[2]), .user_activity(ua[2]), .key(key_w[2]),
      .reset_n_out(rn_w[2]), .busy(busy_w[2]), .done(done_w[2]), .aborted(ab_w[2]), .step(step_w[2]));

   autotype_sequencer #(.n_keys(8), .seq_len(8), .seq(32'h3E02_C11F),
      .step_cycles(SC), .press_cycles(8), .autostart(1), .loop(0), .abort_on_activity(0))
   u3 (.clk(clk), .reset(reset), .start(start[3]), .user_activity(ua[3]), .key(key_w[3]),
      .reset_n_out(rn_w[3]), .busy(busy_w[3]), .done(done_w[3]), .aborted(ab_w[3]), .step(step_w[3]));

   task automatic model_reset();
      for (int i = 0; i < NI; i++) begin
         m_ph[i]   = (P_AUTO[i] != 0) ? 1 : 0;
         m_t[i]    = 0;
         e_key[i]  = 8'h00;
         e_rn[i]   = 1'b0;
         e_busy[i] = 1'b0;
         e_done[i] = 1'b0;
         e_ab[i]   = 1'b0;
         e_step[i] = 0;
      end
   endtask

   initial model_reset();

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         model_reset();
      end else begin
         for (int i = 0; i < NI; i++) begin
            int s;
            int c;
            int code;
            if (m_ph[i] == 1) begin
               s = m_t[i] / SC;
               if (P_LOOP[i] != 0) s = s % P_L[i];
               c = m_t[i] % SC;
               code = int'((P_SEQ[i] >> (4 * s)) & 64'hF);
               if (P_AB[i] != 0 && ua[i]) begin
                  e_key[i] = 8'h00; e_rn[i] = 1'b1; e_busy[i] = 1'b0;
                  e_done[i] = 1'b1; e_ab[i] = 1'b1; e_step[i] = s; m_ph[i] = 2;
               end else begin
                  e_key[i]  = (code >= 1 && code <= 8 && c < P_PC[i]) ? 8'(1 << (code - 1)) : 8'h00;
                  e_rn[i]   = (code != 15);
                  e_busy[i] = 1'b1;
                  if (c == SC - 1 && s == P_L[i] - 1 && P_LOOP[i] == 0) begin
                     m_ph[i] = 2; e_done[i] = 1'b1; e_step[i] = s;
                  end else begin
                     m_t[i] = m_t[i] + 1;
                     e_step[i] = (P_LOOP[i] != 0) ? (m_t[i] / SC) % P_L[i] : m_t[i] / SC;
                  end
               end
            end else begin
               e_key[i]  = 8'h00;
               e_rn[i]   = (m_ph[i] != 0);
               e_busy[i] = 1'b0;
               if (start[i]) begin
                  m_ph[i] = 1; m_t[i] = 0; e_done[i] = 1'b0; e_ab[i] = 1'b0; e_step[i] = 0;
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < NI; i++) begin
         tests++;
         if (key_w[i] !== e_key[i] || rn_w[i] !== e_rn[i] || busy_w[i] !== e_busy[i] ||
             done_w[i] !== e_done[i] || ab_w[i] !== e_ab[i] || step_w[i] !== 6'(e_step[i])) begin
            fails++;
            $display("FAIL model inst%0d e=%0d got key=%h rn=%b busy=%b done=%b ab=%b step=%0d want key=%h rn=%b busy=%b done=%b ab=%b step=%0d",
                     i, e, key_w[i], rn_w[i], busy_w[i], done_w[i], ab_w[i], step_w[i],
                     e_key[i], e_rn[i], e_busy[i], e_done[i], e_ab[i], e_step[i]);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s e=%0d got %0h want %0h", name, e, act, exp);
      end else begin
         $display("[TB] ok %s e=%0d value %0h", name, e, act);
      end
   endtask

   task automatic adv_to(input int target);
      while (e < target) begin
         @(negedge clk);
         e++;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL timeout e=%0d", e);
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < NI; i++) begin
         start[i] = 1'b0;
         ua[i]    = 1'b0;
      end
      repeat (3) @(negedge clk);
      chk("rst_key", 32'(key_w[0]), 32'h0);
      chk("rst_rn", 32'(rn_w[0]), 32'h0);
      chk("rst_busy", 32'(busy_w[0]), 32'h0);
      chk("rst_done", 32'(done_w[0]), 32'h0);
      chk("rst_step", 32'(step_w[0]), 32'h0);
      reset = 1'b0;
      e = 0;

      adv_to(8);   chk("hold_rn_last", 32'(rn_w[0]), 32'h0);
      adv_to(9);   chk("release_rn", 32'(rn_w[0]), 32'h1);
      adv_to(10);  ua[3] = 1'b1;
      adv_to(16);  chk("step2_idx", 32'(step_w[0]), 32'd2);
                   chk("step2_lag", 32'(key_w[0]), 32'h0);
                   chk("i3_same_a", 32'(key_w[3]), 32'h01);
      adv_to(17);  chk("b_press", 32'(key_w[0]), 32'h02);
                   chk("i3_same_b", 32'(key_w[3]), 32'h01);
      adv_to(21);  chk("b_last", 32'(key_w[0]), 32'h02);
      adv_to(22);  chk("b_release", 32'(key_w[0]), 32'h0);
      adv_to(28);  chk("i3_code_c", 32'(key_w[3]), 32'h0);
                   chk("i3_code_c_rn", 32'(rn_w[3]), 32'h1);
      adv_to(30);  ua[3] = 1'b0;
      adv_to(35);  chk("c_press", 32'(key_w[0]), 32'h04);
      adv_to(50);  chk("enter_press", 32'(key_w[0]), 32'h01);
                   start[2] = 1'b1;
      adv_to(51);  start[2] = 1'b0;
      adv_to(70);  chk("i3_done", 32'(done_w[3]), 32'h1);
                   chk("i3_noabort", 32'(ab_w[3]), 32'h0);
                   chk("i3_step", 32'(step_w[3]), 32'd7);
      adv_to(100); ua[1] = 1'b1;
      adv_to(110); ua[1] = 1'b0;
      adv_to(128); chk("done_at_128", 32'(done_w[0]), 32'h1);
                   chk("busy_lag", 32'(busy_w[0]), 32'h1);
                   chk("done_step", 32'(step_w[0]), 32'd15);
      adv_to(129); chk("busy_off", 32'(busy_w[0]), 32'h0);
      adv_to(130); chk("loop_rn", 32'(rn_w[2]), 32'h0);
                   chk("loop_step", 32'(step_w[2]), 32'd0);
                   chk("loop_nodone", 32'(done_w[2]), 32'h0);
      adv_to(200); chk("i1_idle_rn", 32'(rn_w[1]), 32'h0);
                   chk("i1_idle_busy", 32'(busy_w[1]), 32'h0);
                   start[0] = 1'b1;
                   start[1] = 1'b1;
      adv_to(201); start[0] = 1'b0;
                   start[1] = 1'b0;
      adv_to(218); chk("i1_b_press", 32'(key_w[1]), 32'h02);
      adv_to(235); ua[0] = 1'b1;
      adv_to(236); ua[0] = 1'b0;
                   chk("abort_key", 32'(key_w[0]), 32'h0);
                   chk("abort_rn", 32'(rn_w[0]), 32'h1);
                   chk("abort_done", 32'(done_w[0]), 32'h1);
                   chk("abort_flag", 32'(ab_w[0]), 32'h1);
                   chk("abort_step", 32'(step_w[0]), 32'd4);
      adv_to(300); start[0] = 1'b1;
      adv_to(301); start[0] = 1'b0;
      adv_to(303); chk("restart_ab", 32'(ab_w[0]), 32'h0);
                   chk("restart_busy", 32'(busy_w[0]), 32'h1);
      adv_to(352); chk("pre_rst_key", 32'(key_w[0]), 32'h01);
      #1 reset = 1'b1;
      #1;
      chk("async_key", 32'(key_w[0]), 32'h0);
      chk("async_rn", 32'(rn_w[0]), 32'h0);
      @(negedge clk);
      reset = 1'b0;
      e = 0;
      adv_to(9);   chk("rerun_rn", 32'(rn_w[0]), 32'h1);
                   chk("rerun_step", 32'(step_w[0]), 32'd1);
      adv_to(17);  chk("rerun_b", 32'(key_w[0]), 32'h02);
      adv_to(140); chk("rerun_done", 32'(done_w[0]), 32'h1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
